alu_result_stage: RTL and testbench

//  Registered output stage of the ALU core, directly downstream of the shifter, arithmetic, logic and compare units.
//  - Selects one unit result per accepted op and computes status flags.
//  - Buffers up to 2 results in a valid/ready skid queue, so upstream can issue while the consumer stalls.

---
 rtl/alu_result_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: result mux, status flags and 2-entry valid/ready skid queue.
// Optional parity storage enabled by defining ALU_RESULT_PAR_EN.
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] ARITH_OUT,
  input  logic [WIDTH-1:0] LOGIC_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic [1:0]       UNIT_SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ZERO_FLAG,
  output logic             SIGN_FLAG,
  output logic             PAR_FLAG
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             sign;
`ifdef ALU_RESULT_PAR_EN
    logic             par;
`endif
  } entry_t;

  state_t state;
  state_t state_nx;
  entry_t e0;
  entry_t e1;
  entry_t nw;
  logic [WIDTH-1:0] sel_res;
  logic push;
  logic pop;

  assign push = IN_VALID && (state != TWO);
  assign pop  = OUT_READY && (state != EMPTY);

  // Pick the unit result and derive its flags at push time
  always_comb begin
    sel_res = '0;
    case (UNIT_SEL)
      2'b00: sel_res = ARITH_OUT;
      2'b01: sel_res = LOGIC_OUT;
      2'b10: sel_res = CMP_OUT;
      2'b11: sel_res = SHIFT_OUT;
      default: sel_res = '0;
    endcase
    nw      = '0;
    nw.res  = sel_res;
    nw.zero = (sel_res == '0);
    nw.sign = sel_res[WIDTH-1];
`ifdef ALU_RESULT_PAR_EN
    nw.par  = ^sel_res;
`endif
  end

  // Occupancy state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= state_nx;
  end

  // Occupancy next-state from push/pop
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = TWO;
        else if (pop && !push) state_nx = EMPTY;
      end
      TWO: if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Entry storage; entry0 is always the head
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e0 <= '0;
      e1 <= '0;
    end else begin
      case (state)
        EMPTY: if (push) e0 <= nw;
        ONE: begin
          if (push && pop) e0 <= nw;
          else if (push)   e1 <= nw;
        end
        TWO: if (pop) e0 <= e1;
        default: ;
      endcase
    end
  end

  // Handshake and head outputs, masked when empty
  always_comb begin
    IN_READY  = (state != TWO);
    OUT_VALID = (state != EMPTY);
    ALU_OUT   = OUT_VALID ? e0.res : '0;
    ZERO_FLAG = OUT_VALID && e0.zero;
    SIGN_FLAG = OUT_VALID && e0.sign;
`ifdef ALU_RESULT_PAR_EN
    PAR_FLAG  = OUT_VALID && e0.par;
`else
    PAR_FLAG  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors and corner sequences
// for the ALU result stage queue.
module tb_alu_result_stage;

`ifdef ALU_RESULT_PAR_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] arith, logic_o, cmp, shift;
  logic [1:0] sel;
  logic       iv, ir, ov, ordy;
  logic [7:0] aout;
  logic       zf, sf, pf;

  int n_chk = 0;
  int n_fail = 0;

  alu_result_stage #(.WIDTH(8)) dut (
    .CLK(clk), .RST(rst),
    .ARITH_OUT(arith), .LOGIC_OUT(logic_o),
    .CMP_OUT(cmp), .SHIFT_OUT(shift),
    .UNIT_SEL(sel), .IN_VALID(iv),
    .IN_READY(ir), .OUT_VALID(ov),
    .OUT_READY(ordy), .ALU_OUT(aout),
    .ZERO_FLAG(zf), .SIGN_FLAG(sf),
    .PAR_FLAG(pf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       iv;
    bit       ordy;
    bit [1:0] sel;
    bit [7:0] d;
    bit       eov;
    bit       eir;
    bit [7:0] eout;
    bit       ez;
    bit       es;
    bit       ep;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r,
                       input bit [1:0] s,
                       input bit [7:0] d);
    iv      = v;
    ordy    = r;
    sel     = s;
    arith   = 8'($urandom);
    logic_o = 8'($urandom);
    cmp     = 8'($urandom);
    shift   = 8'($urandom);
    case (s)
      2'b00: arith   = d;
      2'b01: logic_o = d;
      2'b10: cmp     = d;
      default: shift = d;
    endcase
  endtask

  task automatic chk_all(input string nm,
                         input bit eov, input bit eir,
                         input bit [7:0] eout,
                         input bit ez, input bit es,
                         input bit ep);
    chk({nm, ".ov"}, {7'd0, ov}, {7'd0, eov});
    chk({nm, ".ir"}, {7'd0, ir}, {7'd0, eir});
    chk({nm, ".out"}, aout, eout);
    chk({nm, ".z"}, {7'd0, zf}, {7'd0, ez});
    chk({nm, ".s"}, {7'd0, sf}, {7'd0, es});
    chk({nm, ".p"}, {7'd0, pf}, {7'd0, ep & PEN});
  endtask

  initial begin
    vt[0] = '{"t2_push81", 1, 1, 2'b11, 8'h81,
              1, 1, 8'h81, 0, 1, 0};
    vt[1] = '{"t2_pop81",  0, 1, 2'b00, 8'h00,
              0, 1, 8'h00, 0, 0, 0};
    vt[2] = '{"t3_push00", 1, 0, 2'b00, 8'h00,
              1, 1, 8'h00, 1, 0, 0};
    vt[3] = '{"t3_push07", 1, 0, 2'b01, 8'h07,
              1, 0, 8'h00, 1, 0, 0};
    vt[4] = '{"t3_ignore", 1, 0, 2'b10, 8'h55,
              1, 0, 8'h00, 1, 0, 0};
    vt[5] = '{"t3_pop00",  0, 1, 2'b00, 8'h00,
              1, 1, 8'h07, 0, 0, 1};
    vt[6] = '{"t4_pushpop", 1, 1, 2'b10, 8'h01,
              1, 1, 8'h01, 0, 0, 1};
    vt[7] = '{"t5_fill",   1, 0, 2'b00, 8'hF0,
              1, 0, 8'h01, 0, 0, 1};
    vt[8] = '{"t5_poponly", 1, 1, 2'b01, 8'hAA,
              1, 1, 8'hF0, 0, 1, 0};
    vt[9] = '{"t5_drain",  0, 1, 2'b00, 8'h00,
              0, 1, 8'h00, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 2'b00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("reset", 0, 1, 8'h00, 0, 0, 0);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].ordy, vt[i].sel, vt[i].d);
      @(posedge clk);
      #1;
      chk_all(vt[i].name, vt[i].eov, vt[i].eir,
              vt[i].eout, vt[i].ez, vt[i].es, vt[i].ep);
    end

    // Two entries held, then async reset mid-stream
    @(negedge clk);
    drive(1, 0, 2'b11, 8'h9C);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 2'b01, 8'h3E);
    @(posedge clk);
    #1;
    chk_all("t1_full", 1, 0, 8'h9C, 0, 1, 0);
    @(negedge clk);
    drive(1, 1, 2'b00, 8'h11);
    rst = 1'b1;
    #1;
    chk_all("t1_async", 0, 1, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("t1_held", 0, 1, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 2'b00, 8'h00);
    @(posedge clk);
    #1;
    chk_all("t1_after", 0, 1, 8'h00, 0, 0, 0);

    // Streaming 0..FF through all units, one per cycle
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i);
      @(negedge clk);
      drive(1, 1, d[1:0], d);
      @(posedge clk);
      #1;
      chk_all($sformatf("t6_%02h", d), 1, 1, d,
              d == 8'h00, d[7], ^d);
    end
    @(negedge clk);
    drive(0, 1, 2'b00, 8'h00);
    @(posedge clk);
    #1;
    chk_all("t6_end", 0, 1, 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
